// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states and the halfword
// queue entry (instruction halfword plus the address it was fetched from).
package fetch_pkg;

  localparam int PC_W     = 32;
  localparam int HW_BYTES = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  typedef logic [15:0] halfword_t;

  typedef struct packed {
    halfword_t       data;
    logic [PC_W-1:0] pc;
  } entry_t;

endpackage

// File: rtl/fetch_unit_halfword_fifo.sv
// Small in-order halfword queue: up to two pushes and one pop per cycle,
// with a synchronous flush used by branch redirects.
module halfword_fifo
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [1:0]    push_n,
  input  entry_t        push0,
  input  entry_t        push1,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t          mem [QDEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_n);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push_n) - CW'(pop);
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (push_n != 2'd0) mem[wr_ptr] <= push0;
      if (push_n == 2'd2) mem[wr_ptr + PW'(1)] <= push1;
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

  always @(posedge clk) begin
    if (!reset && !flush) begin
      assert (int'(count) + int'(push_n) - int'(pop) <= QDEPTH);
      assert (!pop || count != '0);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: word requests to imem, halfword split into a queue,
// valid/ready delivery to the decoder, and flushing on branch redirect.
//
//   state | meaning
//   IDLE  | no request outstanding; issue one when the queue has room for a word
//   WAIT  | request outstanding; data will be queued on ack
//   DROP  | request outstanding but made stale by a redirect; data discarded on ack
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int CW = $clog2(QDEPTH) + 1;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] word_addr;
  logic              take;
  logic              pop;
  logic [1:0]        push_n;
  entry_t            push0;
  entry_t            push1;
  entry_t            head;
  logic [CW-1:0]     count;

  assign word_addr = {fetch_pc[ADDR_W-1:2], 2'b00};
  assign take      = (state == WAIT) && imem_ack && !redirect;
  assign pop       = instr_valid && instr_ready;

  // A fetch_pc pointing at the upper halfword (branch target) skips the lower one.
  always_comb begin
    push_n     = 2'd0;
    push0.data = imem_rdata[15:0];
    push0.pc   = PC_W'(word_addr);
    push1.data = imem_rdata[31:16];
    push1.pc   = PC_W'(word_addr + ADDR_W'(HW_BYTES));
    if (take) begin
      if (fetch_pc[1]) begin
        push_n     = 2'd1;
        push0.data = imem_rdata[31:16];
        push0.pc   = PC_W'(fetch_pc);
      end else begin
        push_n = 2'd2;
      end
    end
  end

  halfword_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push_n(push_n),
    .push0 (push0),
    .push1 (push1),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = head.data;
  assign instr_pc    = ADDR_W'(head.pc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= {RESET_PC[ADDR_W-1:2], 2'b00};
      fetch_pc  <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end else if (count <= CW'(QDEPTH - 2)) begin
            imem_req  <= 1'b1;
            imem_addr <= word_addr;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            if (imem_ack) begin
              imem_req <= 1'b0;
              state    <= IDLE;
            end else begin
              state <= DROP;
            end
          end else if (imem_ack) begin
            fetch_pc <= word_addr + ADDR_W'(2 * HW_BYTES);
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        DROP: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
